// File: rtl/apb_master_fsm.sv
// APB requester: accepts one command at a time on a valid/ready port, runs a
// SETUP->ACCESS transfer with an optional PREADY timeout, and presents the
// result on a response port that is held until consumed.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for cmd_valid
// SETUP  | PSEL high, PENABLE low, one cycle only
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// RESP   | response held on rsp_* until rsp_ready
module apb_master_fsm #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // A zero timeout still needs a legal counter width; the counter then
  // just saturates and never triggers an abort.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt, wait_cnt_nxt;
  logic                cmd_ready_nxt;
  logic                rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_rdata_nxt;
  logic                rsp_err_nxt;
  logic                rsp_timeout_nxt;
  logic                psel_nxt;
  logic                penable_nxt;
  logic                pwrite_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt;

  // State register plus every output register; reset drops the bus at once
  // and discards any pending response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless a state acts.
  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    cmd_ready_nxt   = cmd_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt     = ST_SETUP;
          cmd_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          penable_nxt   = 1'b0;
          pwrite_nxt    = cmd_write;
          paddr_nxt     = cmd_addr;
          pwdata_nxt    = cmd_wdata;
        end
      end

      ST_SETUP: begin
        state_nxt    = ST_ACCESS;
        penable_nxt  = 1'b1;
        wait_cnt_nxt = '0;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
        end else if (TMO_EN && (wait_cnt == CNT_LAST)) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt     = ST_IDLE;
        cmd_ready_nxt = 1'b1;
        rsp_valid_nxt = 1'b0;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm with a 4-cycle timeout: directed vector table,
// randomized transactions against an outcome model, and reset corner cases.
module tb_apb_master_fsm;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_master_fsm #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  int    errors = 0;
  int    checks = 0;
  string cur    = "init";

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;   // PREADY=0 cycles before PREADY=1 in ACCESS
    logic [DW-1:0] prdata;
    logic          slverr;
    int            hold;    // cycles rsp_ready is held low in RESP
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_lat; // edges from accept to rsp_valid visible
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  // Outcome of one transfer from the slave's behaviour alone: either it
  // answers within the timeout window or the requester gives up after TMO
  // ACCESS cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.waits >= TMO) begin
      r.exp_rdata = '0;
      r.exp_err   = 1'b1;
      r.exp_to    = 1'b1;
      r.exp_lat   = 1 + TMO;
    end else begin
      r.exp_rdata = v.write ? '0 : v.prdata;
      r.exp_err   = v.slverr;
      r.exp_to    = 1'b0;
      r.exp_lat   = 2 + v.waits;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    int   k;
    int   acc;
    logic ok;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge PCLK); @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1));
    cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    chk("setup_bus", {PSEL, PENABLE}, 2'b10);
    k = 0; acc = 0; ok = 1'b1;
    while (!rsp_valid && k < 40) begin
      if (PSEL) ok = ok && (PADDR == v.addr) && (PWRITE == v.write) && (PWDATA == v.wdata);
      if (PSEL && PENABLE) begin
        if (acc == v.waits) begin
          PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
        end
        acc++;
      end else begin
        PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      end
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge PCLK); @(negedge PCLK);
      k++;
    end
    PREADY = 1'b0; PSLVERR = 1'b0; rsp_ready = 1'b0;
    chk("latency", k, v.exp_lat);
    chk("penable_cycles", acc, v.exp_lat - 1);
    chk("apb_stable", ok, 1);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    chk("resp_bus", {PSEL, PENABLE, cmd_ready}, 3'b000);
    chk("paddr_hold", PADDR, v.addr);
    ok = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      cmd_valid = 1'b1; cmd_addr = AW'($urandom); cmd_write = 1'($urandom_range(0, 1));
      @(posedge PCLK); @(negedge PCLK);
      ok = ok && rsp_valid && (rsp_rdata == v.exp_rdata) && (rsp_err == v.exp_err)
              && (rsp_timeout == v.exp_to) && !PSEL && !cmd_ready && (PADDR == v.addr);
    end
    if (v.hold > 0) chk("rsp_hold_stable", ok, 1);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("release", {rsp_valid, cmd_ready, PSEL}, 3'b010);
  endtask

  vec_t dir[8];
  vec_t v;
  logic ok;

  initial begin
    //                  wr    addr   wdata          waits prdata         err   hold rdata          e     to    lat
    dir[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0,   32'h0BADF00D, 1'b0, 0, 32'h00000000, 1'b0, 1'b0, 2};
    dir[1] = '{1'b0, 8'h04, 32'h11111111, 3,   32'h12345678, 1'b0, 0, 32'h12345678, 1'b0, 1'b0, 5};
    dir[2] = '{1'b0, 8'h20, 32'h22222222, 0,   32'hAAAA5555, 1'b1, 1, 32'hAAAA5555, 1'b1, 1'b0, 2};
    dir[3] = '{1'b0, 8'h21, 32'h33333333, 2,   32'h0F0F0F0F, 1'b0, 0, 32'h0F0F0F0F, 1'b0, 1'b0, 4};
    dir[4] = '{1'b0, 8'h40, 32'h44444444, 100, 32'h99999999, 1'b0, 0, 32'h00000000, 1'b1, 1'b1, 5};
    dir[5] = '{1'b1, 8'h41, 32'h55555555, 3,   32'h77777777, 1'b0, 0, 32'h00000000, 1'b0, 1'b0, 5};
    dir[6] = '{1'b0, 8'hFF, 32'h66666666, 3,   32'hCAFEF00D, 1'b1, 5, 32'hCAFEF00D, 1'b1, 1'b0, 5};
    dir[7] = '{1'b1, 8'h80, 32'h88888888, 10,  32'h12121212, 1'b0, 2, 32'h00000000, 1'b1, 1'b1, 5};

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    cur = "reset";
    chk("ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 7'b0000001);
    chk("paddr", PADDR, 0);
    chk("pwdata", PWDATA, 0);
    chk("rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cur = $sformatf("dir%0d", i);
      run_txn(dir[i]);
    end

    for (int i = 0; i < 30; i++) begin
      cur = $sformatf("rnd%0d", i);
      v.write = 1'($urandom_range(0, 1));
      v.addr = AW'($urandom); v.wdata = $urandom; v.prdata = $urandom;
      v.waits = $urandom_range(0, 6); v.slverr = 1'($urandom_range(0, 1));
      v.hold = $urandom_range(0, 3);
      v = model(v);
      run_txn(v);
    end

    // Reset while waiting in ACCESS: bus drops at that edge, no response follows.
    cur = "rst_access";
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33;
    @(posedge PCLK); @(negedge PCLK);
    cmd_valid = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    chk("in_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;
    chk("after", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      PREADY = 1'($urandom_range(0, 1)); rsp_ready = 1'($urandom_range(0, 1));
      @(posedge PCLK); @(negedge PCLK);
      ok = ok && !rsp_valid && !PSEL && cmd_ready;
    end
    PREADY = 1'b0; rsp_ready = 1'b0;
    chk("no_response", ok, 1);

    // Reset while a response is pending discards it.
    cur = "rst_resp";
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55;
    @(posedge PCLK); @(negedge PCLK);
    cmd_valid = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hFEEDFACE;
    @(posedge PCLK); @(negedge PCLK);
    PREADY = 1'b0; PSLVERR = 1'b0;
    chk("pending", {rsp_valid, rsp_err}, 2'b11);
    chk("pending_rdata", rsp_rdata, 32'hFEEDFACE);
    PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    PRESET = 1'b0;
    chk("discarded", {rsp_valid, rsp_err, cmd_ready}, 3'b001);
    chk("discarded_rdata", rsp_rdata, 0);

    // Back-to-back after reset still works.
    cur = "post_reset";
    v = '{1'b1, 8'h5A, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0};
    v = model(v);
    run_txn(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
